// File: rtl/divclk_monitor_pkg.sv
// Shared types and defaults for the divided-clock period monitor.
package divclk_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/divclk_monitor_edge_sync.sv
// Synchronizes the asynchronous divided clock into clk_in and flags its rising edges.
module edge_sync
    import divclk_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_in,
    input  logic nrst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Reset value of both flops is 0, so no edge can appear out of reset.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/divclk_monitor.sv
// Measures the divided-clock period in clk_in cycles and compares it with 2*(scale+1).
module divclk_monitor
    import divclk_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             nrst,
    input  logic             div_clk,
    input  logic [7:0]       scale,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             match,
    output logic             stall
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             match_q, match_d;
    logic             stall_q, stall_d;
    logic [CNT_W-1:0] expected;
    logic             rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk_in (clk_in),
        .nrst   (nrst),
        .d      (div_clk),
        .rise   (rise)
    );

    always_comb expected = CNT_W'((32'(scale) + 32'd1) << 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        match_d  = match_q;
        stall_d  = stall_q;
        // Disabling overrides everything, including a rise on this same cycle.
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            stall_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        cnt_d   = '0;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
                        pv_d     = 1'b1;
                        match_d  = (period_d == expected);
                        cnt_d    = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        stall_d = 1'b1;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            match_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            match_q  <= match_d;
            stall_q  <= stall_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign match        = match_q;
    assign stall        = stall_q;

endmodule

// File: tb/tb_divclk_monitor.sv
// Scoreboard bench: the driver predicts each report from raw div_clk edge times, a monitor checks them.
module tb_divclk_monitor;

    logic        clk_in  = 1'b0;
    logic        nrst    = 1'b0;
    logic        div_clk = 1'b0;
    logic        en      = 1'b0;
    logic [7:0]  scale   = 8'd0;
    logic [15:0] period;
    logic        period_valid, match, stall;
    logic [7:0]  period8;
    logic        pv8, match8, stall8;

    always #5 clk_in = ~clk_in;

    divclk_monitor dut (
        .clk_in(clk_in), .nrst(nrst), .div_clk(div_clk), .scale(scale), .en(en),
        .period(period), .period_valid(period_valid), .match(match), .stall(stall)
    );

    divclk_monitor #(.SYNC_STAGES(3), .CNT_W(8)) dut8 (
        .clk_in(clk_in), .nrst(nrst), .div_clk(div_clk), .scale(scale), .en(en),
        .period(period8), .period_valid(pv8), .match(match8), .stall(stall8)
    );

    typedef struct {
        int period;
        bit match;
    } exp_t;

    exp_t sbq[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   last_rise = 0;
    int   pv8_cnt   = 0;
    bit   armed     = 1'b0;
    bit   pv_prev   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            cyc++;
        end
    endtask

    // Reference: a report is the spacing of consecutive rises once armed.
    task automatic model_rise();
        exp_t e;
        if (armed) begin
            e.period = (cyc - last_rise > 65535) ? 65535 : cyc - last_rise;
            e.match  = (e.period == 2 * (int'(scale) + 1));
            sbq.push_back(e);
        end
        armed     = 1'b1;
        last_rise = cyc;
    endtask

    task automatic drive_div(input bit v);
        if (v && !div_clk && en) model_rise();
        div_clk = v;
    endtask

    task automatic wave(input int half, input int n);
        for (int i = 0; i < n; i++) begin
            drive_div(1'b1);
            step(half);
            drive_div(1'b0);
            step(half);
        end
    endtask

    task automatic disable_mon();
        en    = 1'b0;
        armed = 1'b0;
        step(2);
    endtask

    task automatic segment(input int sc, input int half, input int n);
        scale = 8'(sc);
        en    = 1'b1;
        step(3);
        wave(half, n);
        step(3);
        disable_mon();
    endtask

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (period_valid) begin
            check("pv_back_to_back", int'(pv_prev), 0);
            if (sbq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("period", int'(period), e.period);
                check("match", int'(match), int'(e.match));
            end
        end
        pv_prev = period_valid;
        if (pv8) pv8_cnt++;
    end

    initial begin
        int h, s, p8_before;
        #2;
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_match", int'(match), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_period8", int'(period8), 0);
        check("rst_stall8", int'(stall8), 0);
        step(2);
        nrst = 1'b1;
        step(2);

        segment(3, 4, 6);
        segment(0, 1, 6);
        segment(255, 256, 3);

        for (int k = 0; k < 8; k++) begin
            h = int'($urandom_range(1, 10));
            s = ($urandom_range(0, 1) == 1) ? h - 1 : int'($urandom_range(0, 15));
            segment(s, h, int'($urandom_range(3, 6)));
        end

        // Scale moves 3 -> 5 mid-period; the divider follows one period later.
        scale = 8'd3;
        en    = 1'b1;
        step(3);
        wave(4, 3);
        drive_div(1'b1); step(4); drive_div(1'b0); step(2);
        scale = 8'd5;
        step(2);
        drive_div(1'b1); step(6); drive_div(1'b0); step(6);
        wave(6, 3);
        step(3);
        disable_mon();

        // Reset in the middle of a measurement.
        scale = 8'd4;
        en    = 1'b1;
        step(3);
        wave(5, 3);
        drive_div(1'b1); step(5); drive_div(1'b0); step(2);
        nrst = 1'b0;
        #1;
        check("midrst_period", int'(period), 0);
        check("midrst_match", int'(match), 0);
        check("midrst_valid", int'(period_valid), 0);
        check("midrst_period8", int'(period8), 0);
        check("midrst_match8", int'(match8), 0);
        armed = 1'b0;
        step(2);
        nrst = 1'b1;
        step(3);
        wave(5, 3);
        step(3);
        disable_mon();

        // Static div_clk: only the 8-bit counter saturates.
        pv8_cnt = 0;
        scale   = 8'd4;
        en      = 1'b1;
        step(3);
        wave(5, 3);
        step(3);
        check("pv8_count_pre", pv8_cnt, 2);
        p8_before = pv8_cnt;
        step(300);
        check("stall8_set", int'(stall8), 1);
        check("stall_main_clear", int'(stall), 0);
        check("period8_held", int'(period8), 10);
        check("pv8_none_in_hold", pv8_cnt, p8_before);
        drive_div(1'b1); step(5); drive_div(1'b0); step(5);
        drive_div(1'b1); step(5); drive_div(1'b0); step(5);
        check("pv8_after_rearm", pv8_cnt, p8_before + 1);
        check("period8_after_rearm", int'(period8), 10);
        check("stall8_sticky", int'(stall8), 1);
        // Rise reaches the detector on the same cycle en drops.
        div_clk = 1'b1;
        step(2);
        en    = 1'b0;
        armed = 1'b0;
        step(10);
        check("stall8_cleared", int'(stall8), 0);
        check("pv8_none_on_drop", pv8_cnt, p8_before + 1);
        div_clk = 1'b0;
        step(10);

        check("queue_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divclk_monitor.md
DIVCLK_MONITOR -- requirements
Module: divclk_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on div_clk, legal range 2..3.
REQ-002 Parameter CNT_W, default 16: width of the period counter and of the period output.
REQ-003 clk_in  input  1: single system clock; every flop samples on its rising edge.
REQ-004 nrst  input  1: reset, asynchronous assert, active-low.
REQ-005 div_clk  input  1: divided clock from the clock divider; treated as asynchronous to clk_in.
REQ-006 scale  input  8: divider scale setting, sampled on clk_in, used only to form the expected period.
REQ-007 en  input  1: monitor enable; when 0, the block is held in IDLE.
REQ-008 period  output  CNT_W: last measured div_clk period, in clk_in cycles.
REQ-009 period_valid  output  1: one-cycle pulse when period updates.
REQ-010 match  output  1: last measured period equals expected period; valid while period_valid was last seen.
REQ-011 stall  output  1: sticky flag; no div_clk rising edge seen within a full counter span.

Function
REQ-012 div_clk SHALL pass through SYNC_STAGES flops, then a one-flop edge detector; a rise is detected on the cycle where synced=1 and the previous synced value=0.
REQ-013 The state machine SHALL have three states: IDLE, ARM and MEASURE.
REQ-014 IDLE -> ARM when en=1; any state -> IDLE when en=0, with the counter cleared and outputs held.
REQ-015 ARM: on the first detected rise, clear the counter and go to MEASURE; no period_valid is issued.
REQ-016 MEASURE: the counter increments by 1 every cycle and saturates at 2^CNT_W-1.
REQ-017 MEASURE, detected rise: period <= counter+1 (saturating), period_valid=1 on the next cycle, counter <= 0; edges N cycles apart SHALL report period=N.
REQ-018 Expected period = 2*(scale+1), computed in CNT_W bits (scale=0 -> 2, scale=255 -> 512).
REQ-019 match SHALL register (period_next == expected) in the same cycle that period updates.
REQ-020 Counter saturation in MEASURE with no rise: set stall=1 and go to ARM; period is unchanged and no period_valid is issued.
REQ-021 stall SHALL clear only on reset, or on a transition of en to 0.
REQ-022 A scale change mid-measurement SHALL NOT restart the measurement; it affects only the next compare.
REQ-023 Rise detected on the same cycle as en falling: en wins, so the state goes to IDLE and no period_valid is issued.
REQ-024 period_valid SHALL never be asserted on two consecutive cycles.

Reset
REQ-025 nrst=0 SHALL asynchronously force state=IDLE, counter=0, synchronizer and edge flops=0, period=0, period_valid=0, match=0, stall=0.
REQ-026 After nrst releases, the first measurement SHALL begin only after an ARM edge; no spurious rise is reported from the reset value of the synchronizer.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/ARM/MEASURE) and the default CNT_W and SYNC_STAGES constants.
REQ-028 The synchronizer plus edge detector SHALL be one sub-module, edge_sync (params SYNC_STAGES; ports clk_in, nrst, d, rise).
REQ-029 All other logic SHALL reside in divclk_monitor; target size is 120-400 lines of RTL.

Verification
REQ-030 Drive div_clk with an ideal divider at scale=3 (toggle every 4 cycles), en=1 -> from the second rise onward: period=8, match=1, one period_valid per 8 cycles.
REQ-031 scale=0 (div_clk toggles every cycle) -> period=2, match=1; scale=255 -> period=512, match=1.
REQ-032 Hold div_clk static with CNT_W=8 -> stall=1 after 255 cycles in MEASURE, state=ARM, period unchanged, no period_valid.
REQ-033 Change scale from 3 to 5 mid-period -> the current report is period=8 with match=0; after the divider follows, period=12 with match=1.
REQ-034 Assert nrst low mid-measurement, then release -> all outputs read 0 immediately; the first period_valid comes only after ARM plus one full period.
REQ-035 Drop en to 0 on the same cycle as a detected rise -> no period_valid, state=IDLE, stall cleared.
